// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider FSM states and the common flag bundle.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
        logic n;
    } alu_flags_t;

    // Two's-complement negation at datapath width
    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
        return ~x + DATA_W'(1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract b, keep or restore.
module div_step
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] next_rem,
    output logic [DATA_W-1:0] next_quo
);

    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] diff;
    logic              fits;

    // rem < b always holds, so the difference fits in DATA_W bits whenever it is kept
    always_comb begin
        shifted  = {rem, quo[DATA_W-1]};
        fits     = (shifted >= {1'b0, b});
        diff     = shifted[DATA_W-1:0] - b;
        next_rem = fits ? diff : shifted[DATA_W-1:0];
        next_quo = {quo[DATA_W-2:0], fits};
    end

endmodule

// File: rtl/divider.sv
// Iterative restoring divider with start/busy/done handshake and ALU flags.
// Define DIVIDER_SIGNED_EN for two's-complement operands; otherwise unsigned only.
module divider
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] remainder,
    output logic              z_flag,
    output logic              c_flag,
    output logic              v_flag,
    output logic              n_flag
);

    div_state_t        state;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvs;
    logic [CNT_W-1:0]  count;
    logic              neg_q;
    logic              neg_r;
    logic              ovf;
    alu_flags_t        flags;

    logic [DATA_W-1:0] step_rem;
    logic [DATA_W-1:0] step_quo;
    logic [DATA_W-1:0] fix_q;
    logic [DATA_W-1:0] fix_r;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic              sign_a;
    logic              sign_b;
    logic              ovf_in;

`ifdef DIVIDER_SIGNED_EN
    assign sign_a = a[DATA_W-1];
    assign sign_b = b[DATA_W-1];
    assign ovf_in = (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1);
`else
    assign sign_a = 1'b0;
    assign sign_b = 1'b0;
    assign ovf_in = 1'b0;
`endif

    // Operands are divided as magnitudes; signs are reapplied when the result is captured
    assign mag_a = sign_a ? negate(a) : a;
    assign mag_b = sign_b ? negate(b) : b;

    div_step u_step (
        .rem      (rem),
        .quo      (quo),
        .b        (dvs),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    assign fix_q = neg_q ? negate(step_quo) : step_quo;
    assign fix_r = neg_r ? negate(step_rem) : step_rem;

    assign z_flag = flags.z;
    assign c_flag = flags.c;
    assign v_flag = flags.v;
    assign n_flag = flags.n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            remainder <= '0;
            flags     <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            count     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rem   <= '0;
                        quo   <= mag_a;
                        dvs   <= mag_b;
                        count <= '0;
                        neg_q <= sign_a ^ sign_b;
                        neg_r <= sign_a;
                        ovf   <= ovf_in;
                        if (b == '0) begin
                            // Divide by zero completes immediately without iterating
                            state     <= DONE;
                            done      <= 1'b1;
                            result    <= '1;
                            remainder <= a;
                            flags     <= '{z: 1'b0, c: 1'b1, v: 1'b0, n: 1'b1};
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rem   <= step_rem;
                    quo   <= step_quo;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(DATA_W - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= fix_q;
                        remainder <= fix_r;
                        flags     <= '{z: (fix_q == '0), c: 1'b0, v: ovf,
                                       n: fix_q[DATA_W-1]};
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for divider; expectations adapt when DIVIDER_SIGNED_EN is defined.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] remainder;
    logic        z_flag;
    logic        c_flag;
    logic        v_flag;
    logic        n_flag;

    int vectors     = 0;
    int miscompares = 0;

    divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .z_flag    (z_flag),
        .c_flag    (c_flag),
        .v_flag    (v_flag),
        .n_flag    (n_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Flags packed as {z, c, v, n}
    task automatic check_out(input string tag, input logic [31:0] q, input logic [31:0] r,
                             input logic [3:0] f);
        check({tag, "_result"}, result, q);
        check({tag, "_remainder"}, remainder, r);
        check({tag, "_flags"}, 32'({z_flag, c_flag, v_flag, n_flag}), 32'(f));
    endtask

    task automatic start_op(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the first negedge after the accepting edge; counts cycles until done
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                             input int inject_at);
        int cyc;
        int nb;
        cyc = 1;
        nb  = 0;
        if (busy) nb++;
        while (!done && cyc < 100) begin
            if (cyc == inject_at) begin
                a     = 32'd3;
                b     = 32'd1;
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy) nb++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    endtask

    initial begin
        int pulses;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_out("rst", 32'h0, 32'h0, 4'b0000);
        rst = 1'b0;

        // 100 / 7
        start_op(32'd100, 32'd7);
        wait_done("basic", 33, 32, 0);
        check_out("basic", 32'd14, 32'd2, 4'b0000);
        @(negedge clk);
        check("basic_done_pulse", 32'(done), 32'd0);

        // 5 / 9, then a new start in its done cycle
        start_op(32'd5, 32'd9);
        wait_done("zeroq", 33, 32, 0);
        check_out("zeroq", 32'd0, 32'd5, 4'b1000);
        a     = 32'hFFFF_FFFF;
        b     = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_low", 32'(done), 32'd0);
        check("b2b_busy_high", 32'(busy), 32'd1);
        wait_done("b2b", 33, 32, 5);
        check_out("b2b", 32'hFFFF_FFFF, 32'h0, 4'b0001);

        // Divide by zero
        start_op(32'h1234, 32'h0);
        wait_done("div0", 1, 0, 0);
        check_out("div0", 32'hFFFF_FFFF, 32'h1234, 4'b0101);

        // Most-negative by all-ones
        start_op(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("ovf", 33, 32, 0);
`ifdef DIVIDER_SIGNED_EN
        check_out("ovf", 32'h8000_0000, 32'h0, 4'b0011);
`else
        check_out("ovf", 32'h0, 32'h8000_0000, 4'b1000);
`endif

        // -7 / 2
        start_op(32'hFFFF_FFF9, 32'd2);
        wait_done("neg7", 33, 32, 0);
`ifdef DIVIDER_SIGNED_EN
        check_out("neg7", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b0001);
`else
        check_out("neg7", 32'h7FFF_FFFC, 32'h1, 4'b0000);
`endif

        // Reset in the middle of a run
        start_op(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check_out("midrst", 32'h0, 32'h0, 4'b0000);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);
        check("midrst_idle_busy", 32'(busy), 32'd0);

        start_op(32'd7, 32'd7);
        wait_done("after_rst", 33, 32, 0);
        check_out("after_rst", 32'd1, 32'd0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
